instr_issuer: RTL

- Upstream stage of the LED Controller.
- Buffers 32-bit LED instructions (op_code [31:24], index [23:16], payload [15:0]) from the host-side writer in a small FIFO.
- Presents each instruction to the Controller's `instruction` input as a single-cycle pulse, only when the Controller reports READY.
- Holds NOP (all zero) at all other times, so a level-sensitive op such as SEND_LATCH never retriggers.

---
 rtl/led_pkg.sv | 28 ++
 rtl/instr_issuer_if.sv | 19 +
 rtl/instr_issuer_sync_fifo.sv | 58 +++++
 rtl/instr_issuer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared LED controller definitions: op codes, controller states,
// instruction field positions and the issuer FSM state type.
package led_pkg;

  localparam logic [7:0] OP_NOP                 = 8'd0;
  localparam logic [7:0] OP_BUFFER_DATA         = 8'd1;
  localparam logic [7:0] OP_SEND_LATCH          = 8'd4;
  localparam logic [7:0] OP_SET_CONTINUOUS_SKIP = 8'd20;
  localparam logic [7:0] OP_MAX                 = OP_SET_CONTINUOUS_SKIP;

  localparam logic [3:0] ST_READY    = 4'd0;
  localparam logic [3:0] ST_WAIT_LAT = 4'd1;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 24;
  localparam int IDX_MSB = 23;
  localparam int IDX_LSB = 16;

  localparam logic [31:0] NOP_WORD = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT
  } iss_state_e;

endpackage

// File: rtl/instr_issuer_if.sv
// Writer-to-issuer instruction handshake.
// A push happens on a clock edge where in_valid && in_ready.
interface instr_issuer_if;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;

  modport master (
    output in_instr,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_instr,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/instr_issuer_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_issuer.sv
// Buffers LED instructions and pulses each one to the controller when READY.
// Define ISSUER_TIMEOUT_EN to add the WAIT_READY watchdog and timeout_err.
module instr_issuer
  import led_pkg::*;
#(
  parameter int DEPTH = 4
`ifdef ISSUER_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instr_issuer_if.slave          wr,
  input  logic                   flush,
  input  logic [3:0]             ctrl_state,
  output logic [31:0]            instruction,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
`ifdef ISSUER_TIMEOUT_EN
  , output logic                 timeout_err
`endif
);
  localparam int AW = $clog2(DEPTH);

  iss_state_e  state_q;
  logic [31:0] instr_q;
  logic [31:0] head;
  logic        full;
  logic        empty;
  logic        pop;
  logic        ctrl_ready;

  assign ctrl_ready  = (ctrl_state == ST_READY);
  assign wr.in_ready = !full;
  assign pop         = (state_q == S_IDLE) && !empty
                       && ctrl_ready && !flush;
  assign instruction = instr_q;
  assign busy        = (state_q != S_IDLE) || !empty;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr.in_valid),
    .pop   (pop),
    .flush (flush),
    .wdata (wr.in_instr),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

`ifdef ISSUER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  assign timeout_err = err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      instr_q <= NOP_WORD;
`ifdef ISSUER_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else if (flush) begin
      state_q <= S_IDLE;
      instr_q <= NOP_WORD;
`ifdef ISSUER_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            instr_q <= head;
            state_q <= S_ISSUE;
          end else begin
            instr_q <= NOP_WORD;
          end
        end
        S_ISSUE: begin
          instr_q <= NOP_WORD;
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          instr_q <= NOP_WORD;
          state_q <= S_WAIT;
`ifdef ISSUER_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        S_WAIT: begin
          instr_q <= NOP_WORD;
          if (ctrl_ready) begin
            state_q <= S_IDLE;
`ifdef ISSUER_TIMEOUT_EN
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            // Give up on this op; the next issue still needs READY
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
`endif
          end
        end
        default: begin
          instr_q <= NOP_WORD;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
